// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane-select width.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte offset within a word selects one of four lanes.
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_FIN
  } state_e;

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: extracts and extends sub-word loads, and merges
// sub-word store data into an existing word. Purely combinational.
module lsu_lane_mux
  import lsu_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic [WL-1:0]     word_i,
  input  logic [WL-1:0]     data_i,
  input  logic [LANE_W-1:0] off_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  output logic [WL-1:0]     load_o,
  output logic [WL-1:0]     merge_o
);

  logic [LANE_W+2:0] sh;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [WL-1:0]     mask;
  logic [WL-1:0]     data_sh;

  assign sh = {off_i, 3'b000};

  always_comb begin
    lane_b  = 8'(word_i >> sh);
    lane_h  = 16'(word_i >> sh);
    load_o  = word_i;
    mask    = '1;
    case (size_i)
      SZ_BYTE: begin
        load_o = sext_i ? {{(WL-8){lane_b[7]}}, lane_b} : {{(WL-8){1'b0}}, lane_b};
        mask   = WL'(8'hFF) << sh;
      end
      SZ_HALF: begin
        load_o = sext_i ? {{(WL-16){lane_h[15]}}, lane_h} : {{(WL-16){1'b0}}, lane_h};
        mask   = WL'(16'hFFFF) << sh;
      end
      default: ;
    endcase
    // A full-word mask makes the merge degenerate to a plain word write.
    data_sh = data_i << sh;
    merge_o = (word_i & ~mask) | (data_sh & mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-addressed memory; sub-word stores use read-modify-write.
// Holds busy until FIN; done (with err on rejected requests) pulses for one cycle.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WL    = 32,
  parameter int DEPTH = 65
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [WL-1:0] core_addr,
  input  logic [WL-1:0] core_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [WL-1:0] core_rdata,
  output logic [WL-1:0] mem_addr,
  output logic          write_EN,
  output logic [WL-1:0] writeData,
  input  logic [WL-1:0] readData
);

  state_e              state_q, state_d;
  logic                op_we_q, op_we_d;
  logic                op_sext_q, op_sext_d;
  logic [1:0]          op_size_q, op_size_d;
  logic [LANE_W-1:0]   op_off_q, op_off_d;
  logic [WL-1:0]       op_wdata_q, op_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wen_q, wen_d;
  logic [WL-1:0]       rdata_q, rdata_d;
  logic [WL-1:0]       maddr_q, maddr_d;
  logic [WL-1:0]       wdat_q, wdat_d;

  logic [WL-1:0]       word_idx;
  logic [WL-1:0]       load_val;
  logic [WL-1:0]       merge_val;
  logic                req_bad;

  assign word_idx = {2'b00, core_addr[WL-1:2]};
  assign req_bad  = (size == 2'b11)
                 || (size == SZ_HALF && core_addr[0])
                 || (size == SZ_WORD && core_addr[1:0] != 2'b00)
                 || (word_idx >= WL'(DEPTH));

  // Both load extraction (ACCESS) and store merge (RMW_RD) read the same memory word.
  lsu_lane_mux #(.WL(WL)) u_lane (
    .word_i  (readData),
    .data_i  (op_wdata_q),
    .off_i   (op_off_q),
    .size_i  (op_size_q),
    .sext_i  (op_sext_q),
    .load_o  (load_val),
    .merge_o (merge_val)
  );

  always_comb begin
    state_d    = state_q;
    op_we_d    = op_we_q;
    op_sext_d  = op_sext_q;
    op_size_d  = op_size_q;
    op_off_d   = op_off_q;
    op_wdata_d = op_wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wen_d      = 1'b0;
    rdata_d    = rdata_q;
    maddr_d    = maddr_q;
    wdat_d     = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_we_d    = we;
          op_sext_d  = sign_ext;
          op_size_d  = size;
          op_off_d   = core_addr[LANE_W-1:0];
          op_wdata_d = core_wdata;
          maddr_d    = word_idx;
          if (req_bad) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (!we || size == SZ_WORD) begin
            state_d = ST_ACCESS;
            if (we) begin
              wen_d  = 1'b1;
              wdat_d = core_wdata;
            end
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_ACCESS: begin
        if (!op_we_q) rdata_d = load_val;
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      ST_RMW_RD: begin
        wdat_d  = merge_val;
        wen_d   = 1'b1;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      op_we_q    <= 1'b0;
      op_sext_q  <= 1'b0;
      op_size_q  <= SZ_BYTE;
      op_off_q   <= '0;
      op_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      rdata_q    <= '0;
      maddr_q    <= '0;
      wdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_we_q    <= op_we_d;
      op_sext_q  <= op_sext_d;
      op_size_q  <= op_size_d;
      op_off_q   <= op_off_d;
      op_wdata_q <= op_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wen_q      <= wen_d;
      rdata_q    <= rdata_d;
      maddr_q    <= maddr_d;
      wdat_q     <= wdat_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign write_EN   = wen_q;
  assign core_rdata = rdata_q;
  assign mem_addr   = maddr_q;
  assign writeData  = wdat_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the word-addressed data_mem port on behalf of the core.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word reads and writes.
- Sub-word stores use a two-access read-modify-write.
- Sits between the execute stage and data memory. It stalls the core via busy until each request completes.

Parameters:
- WL, 32, data and address width in bits.
- DEPTH, 65, number of words in the attached memory. Legal word indices are 0..DEPTH-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  1  core request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- core_addr  in  WL  byte address.
- core_wdata  in  WL  store data; the low byte or half is used for sub-word stores.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on a rejected request.
- core_rdata  out  WL  load result, held until the next successful load.
- mem_addr  out  WL  word index = core_addr >> 2.
- write_EN  out  1  memory write enable.
- writeData  out  WL  memory write data.
- readData  in  WL  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async): state IDLE.
  - busy, done, err, write_EN = 0; core_rdata, mem_addr, writeData = 0.
  - write_EN drops immediately on RST assertion, not at the next edge.
- All outputs are registered.
- Byte lanes are little-endian: byte k of a word = bits 8k+7:8k.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, FIN.
- IDLE, req=1: latch we, size, sign_ext, addr[1:0] and wdata. Drive mem_addr = core_addr>>2. Validate the request:
  - size=11 is illegal.
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Word index >= DEPTH is out of range.
  - Invalid: go to FIN with err set. No memory access, write_EN never asserts.
  - Valid load or word store: go to ACCESS. A word store asserts write_EN with writeData = wdata in the same edge.
  - Valid sub-word store: go to RMW_RD.
- ACCESS:
  - Load: extract the lane from readData, extend it, and register it into core_rdata.
  - Word store: the write occurs at this cycle's closing edge; clear write_EN on exit.
  - Next state FIN.
- RMW_RD: capture readData, merge the byte/half into its lane, set writeData and assert write_EN, next RMW_WR.
- RMW_WR: the write occurs at the closing edge; clear write_EN; next FIN.
- FIN: done=1 (err=1 if rejected) for exactly this cycle; next IDLE. busy=0 is seen from the following cycle.
- Latency, counted from the req-sampled edge to done high: load and SW = 2 cycles; SB/SH = 3 cycles; rejected = 1 cycle.
- req while busy is ignored, not queued.
- Back-to-back: a new req is accepted on the first IDLE cycle after FIN. Throughput is one load per 3 cycles.
- write_EN is high for exactly one cycle per successful store and never on loads.
- A failed request leaves core_rdata unchanged.
- RST mid-operation aborts the request. No partial write is issued if reset lands in RMW_RD.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - lane-select width constant.
- One combinational sub-module, lsu_lane_mux, handles:
  - load extraction plus sign/zero extension from (word, offset, size, sign_ext).
  - store merge from (old word, new data, offset, size).
- lsu_lane_mux is reused by both the ACCESS and RMW_RD paths.

Test Plan:
Memory is preloaded with word 3 = 0x8899AABB.
1. LW core_addr 0x0C -> core_rdata 0x8899AABB; done 2 cycles after req; err 0; write_EN never high.
2. LB sign_ext=1 at 0x0D -> 0xFFFFFFAA. LBU at 0x0D -> 0x000000AA. LH sign_ext=1 at 0x0E -> 0xFFFF8899.
3. SB 0x0E, wdata 0x00000011 -> write_EN high exactly 1 cycle, writeData 0x8811AABB, done at cycle 3; a subsequent LW 0x0C reads 0x8811AABB.
4. SH 0x0D, or size=11, or LW 0x104 (word 65) -> done and err pulse 1 cycle after req, no write_EN, memory and core_rdata unchanged.
5. req held high continuously with two queued LW requests -> the second is accepted only on the IDLE cycle after FIN; busy is never low during an access.
6. RST pulsed asynchronously mid-cycle while in RMW_RD of SB 0x0C -> write_EN and busy drop immediately, word 3 unchanged, next LW completes normally.
